// File: rtl/dut_adc_serial_model_if.sv
// ADC serial link bundle: conversion start, serial clock, pattern select,
// SDOUT lanes and the model's status pulses. The controller side is the
// master, the ADC model is the slave.
interface dut_adc_serial_model_if #(
  parameter int NUM_CH = 2
);
  logic              ADC_CNVST;
  logic              ADC_SCLK;
  logic [1:0]        MODE;
  logic [NUM_CH-1:0] ADC_SDOUT;
  logic              BUSY;
  logic              FRAME_DONE;
  logic              FRAME_ABORT;

  modport master (
    output ADC_CNVST,
    output ADC_SCLK,
    output MODE,
    input  ADC_SDOUT,
    input  BUSY,
    input  FRAME_DONE,
    input  FRAME_ABORT
  );

  modport slave (
    input  ADC_CNVST,
    input  ADC_SCLK,
    input  MODE,
    output ADC_SDOUT,
    output BUSY,
    output FRAME_DONE,
    output FRAME_ABORT
  );
endinterface

// File: rtl/dut_adc_serial_model.sv
// Multi-channel SAR ADC behavioural model with a CNVST/SCLK/SDOUT serial
// readout. CNVST and SCLK are oversampled on SYSCLK (2-flop sync plus a
// registered edge detector), so every input event acts three SYSCLK edges
// after it is first sampled.
// Optional feature macro: ADC_MODEL_BUSY_IND_EN -- when defined, each frame
// starts with a busy-indicator bit (lanes drive 0 at end of conversion) and
// is DATA_WIDTH+1 bits long; otherwise the MSB is presented directly.
module dut_adc_serial_model #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_CH      = 2,
  parameter int                    CONV_CYCLES = 140,
  parameter logic [DATA_WIDTH-1:0] SEED        = DATA_WIDTH'(16'hABCD),
  parameter logic [DATA_WIDTH-1:0] CH_OFFSET   = DATA_WIDTH'(16'h0100),
  parameter logic [DATA_WIDTH-1:0] STEP        = DATA_WIDTH'(1)
) (
  input  logic                 SYSCLK,
  input  logic                 RESET_N,
  dut_adc_serial_model_if.slave adc
);

`ifdef ADC_MODEL_BUSY_IND_EN
  // Leading busy-indicator bit: the shift register holds {0, word}.
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif

  localparam int CC_W = $clog2(CONV_CYCLES);
  localparam int BC_W = $clog2(FRAME_BITS);
  localparam logic [CC_W-1:0] CONV_LAST = CC_W'(CONV_CYCLES - 1);
  localparam logic [BC_W-1:0] BITS_LAST = BC_W'(FRAME_BITS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic cnvst_s1_reg, cnvst_s2_reg, cnvst_s3_reg, cnvst_rise_reg;
  logic sclk_s1_reg, sclk_s2_reg, sclk_s3_reg, sclk_rise_reg, sclk_fall_reg;

  logic [1:0]      state_reg, state_next;
  logic [CC_W-1:0] conv_cnt_reg, conv_cnt_next;
  logic [BC_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [1:0]      mode_reg, mode_next;
  logic            parity_reg, parity_next;
  logic            abort_reg, abort_next;

  logic load_en;
  logic shift_en;
  logic advance_en;

  logic [NUM_CH-1:0] lane_bit;

  // Synchronise CNVST/SCLK and register their edges (CNVST falls are unused).
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnvst_s1_reg   <= 1'b0;
      cnvst_s2_reg   <= 1'b0;
      cnvst_s3_reg   <= 1'b0;
      cnvst_rise_reg <= 1'b0;
      sclk_s1_reg    <= 1'b0;
      sclk_s2_reg    <= 1'b0;
      sclk_s3_reg    <= 1'b0;
      sclk_rise_reg  <= 1'b0;
      sclk_fall_reg  <= 1'b0;
    end else begin
      cnvst_s1_reg   <= adc.ADC_CNVST;
      cnvst_s2_reg   <= cnvst_s1_reg;
      cnvst_s3_reg   <= cnvst_s2_reg;
      cnvst_rise_reg <= cnvst_s2_reg & ~cnvst_s3_reg;
      sclk_s1_reg    <= adc.ADC_SCLK;
      sclk_s2_reg    <= sclk_s1_reg;
      sclk_s3_reg    <= sclk_s2_reg;
      sclk_rise_reg  <= sclk_s2_reg & ~sclk_s3_reg;
      sclk_fall_reg  <= ~sclk_s2_reg & sclk_s3_reg;
    end
  end

  // Frame sequencing: idle, conversion timer, serial readout, completion.
  always_comb begin
    state_next    = state_reg;
    conv_cnt_next = conv_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    mode_next     = mode_reg;
    parity_next   = parity_reg;
    abort_next    = 1'b0;
    load_en       = 1'b0;
    shift_en      = 1'b0;
    advance_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cnvst_rise_reg) begin
          state_next    = ST_CONV;
          conv_cnt_next = '0;
          mode_next     = adc.MODE;
        end
      end
      ST_CONV: begin
        // A CNVST rise here is deliberately ignored.
        if (conv_cnt_reg == CONV_LAST) begin
          state_next   = ST_READ;
          load_en      = 1'b1;
          bit_cnt_next = '0;
        end else begin
          conv_cnt_next = conv_cnt_reg + 1'b1;
        end
      end
      ST_READ: begin
        if (cnvst_rise_reg) begin
          // Restart before the frame finished: abort, keep val unchanged.
          state_next    = ST_CONV;
          conv_cnt_next = '0;
          mode_next     = adc.MODE;
          abort_next    = 1'b1;
        end else begin
          shift_en = sclk_fall_reg;
          if (sclk_rise_reg) begin
            if (bit_cnt_reg == BITS_LAST) begin
              state_next = ST_DONE;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        advance_en   = 1'b1;
        parity_next  = ~parity_reg;
        bit_cnt_next = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_IDLE;
      conv_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      mode_reg     <= 2'd0;
      parity_reg   <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      conv_cnt_reg <= conv_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      mode_reg     <= mode_next;
      parity_reg   <= parity_next;
      abort_reg    <= abort_next;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [DATA_WIDTH-1:0] CH_SEED = SEED + CH_OFFSET * DATA_WIDTH'(gi);

    logic [DATA_WIDTH-1:0] val_reg;
    logic [DATA_WIDTH-1:0] word;
    logic [FRAME_BITS-1:0] shift_reg;

    // Output word for this channel according to the captured pattern mode.
    always_comb begin
      word = val_reg;
      case (mode_reg)
        2'd0:    word = val_reg;
        2'd1:    word = CH_SEED;
        2'd2:    word = ~val_reg;
        default: word = parity_reg ? ~CH_SEED : CH_SEED;
      endcase
    end

    // Ramp value advances once per completed frame, in every mode.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        val_reg <= CH_SEED;
      end else if (advance_en) begin
        val_reg <= val_reg + STEP;
      end
    end

    // Load at end of conversion, shift MSB-first on SCLK falls, zero-fill.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        shift_reg <= '0;
      end else if (load_en) begin
        shift_reg <= FRAME_BITS'(word);
      end else if (shift_en) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
      end
    end

    assign lane_bit[gi] = shift_reg[FRAME_BITS-1];
  end

  // Lanes carry data through the completion cycle, otherwise idle high.
  assign adc.ADC_SDOUT   = (state_reg == ST_READ || state_reg == ST_DONE) ? lane_bit : '1;
  assign adc.BUSY        = (state_reg == ST_CONV);
  assign adc.FRAME_DONE  = (state_reg == ST_DONE);
  assign adc.FRAME_ABORT = abort_reg;

endmodule

// File: tb/tb_dut_adc_serial_model.sv
// Bench for dut_adc_serial_model: two instances run in lockstep (defaults,
// and SEED=16'hFFFF single-lane for ramp wrap). Frames are driven as a
// controller would; captured words are compared with a frame-level model.
// Follows ADC_MODEL_BUSY_IND_EN when defined for the build.
`timescale 1ns/1ps
module tb_dut_adc_serial_model;
  localparam int DW   = 16;
  localparam int CONV = 140;
`ifdef ADC_MODEL_BUSY_IND_EN
  localparam int FBITS = DW + 1;
`else
  localparam int FBITS = DW;
`endif

  logic SYSCLK = 1'b0;
  logic RESET_N;
  always #5 SYSCLK = ~SYSCLK;

  dut_adc_serial_model_if #(.NUM_CH(2)) a_if ();
  dut_adc_serial_model_if #(.NUM_CH(1)) b_if ();

  assign b_if.ADC_CNVST = a_if.ADC_CNVST;
  assign b_if.ADC_SCLK  = a_if.ADC_SCLK;
  assign b_if.MODE      = a_if.MODE;

  dut_adc_serial_model #(.DATA_WIDTH(DW), .NUM_CH(2), .CONV_CYCLES(CONV)) u_dut_a (
    .SYSCLK (SYSCLK),
    .RESET_N(RESET_N),
    .adc    (a_if.slave)
  );

  dut_adc_serial_model #(.DATA_WIDTH(DW), .NUM_CH(1), .CONV_CYCLES(CONV), .SEED(16'hFFFF)) u_dut_b (
    .SYSCLK (SYSCLK),
    .RESET_N(RESET_N),
    .adc    (b_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  // Reference model state: one value per lane plus frame parity.
  logic [DW-1:0] seed_a [2];
  logic [DW-1:0] val_a  [2];
  logic [DW-1:0] val_b;
  bit            par;

  logic [DW:0] cap_a [2];
  logic [DW:0] cap_b;

  int done_a = 0, done_b = 0, abort_a = 0, abort_b = 0;

  // Count status pulses, sampled away from the active edge.
  always @(negedge SYSCLK) begin
    if (a_if.FRAME_DONE)  done_a++;
    if (b_if.FRAME_DONE)  done_b++;
    if (a_if.FRAME_ABORT) abort_a++;
    if (b_if.FRAME_ABORT) abort_b++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] v, input logic [DW-1:0] s,
                                               input logic [1:0] md, input bit p);
    case (md)
      2'd0:    return v;
      2'd1:    return s;
      2'd2:    return ~v;
      default: return p ? ~s : s;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      seed_a[c] = 16'hABCD + 16'(c) * 16'h0100;
      val_a[c]  = seed_a[c];
    end
    val_b = 16'hFFFF;
    par   = 1'b0;
  endtask

  task automatic model_frame_done();
    for (int c = 0; c < 2; c++) val_a[c] = val_a[c] + 16'd1;
    val_b = val_b + 16'd1;
    par   = ~par;
  endtask

  // Raise CNVST at a negedge; BUSY should be seen on the 4th negedge.
  task automatic start_conv(input logic [1:0] md);
    int lat;
    a_if.MODE      = md;
    a_if.ADC_CNVST = 1'b1;
    lat = 0;
    while (!a_if.BUSY && lat < 20) begin
      @(negedge SYSCLK);
      lat++;
      if (lat == 2) a_if.ADC_CNVST = 1'b0;
    end
    a_if.ADC_CNVST = 1'b0;
    check_value("busy_latency", lat, 4);
    check_value("busy_b", b_if.BUSY, 1);
    // Mode must already be captured; scramble it for the rest of the frame.
    a_if.MODE = 2'($urandom_range(0, 3));
  endtask

  // Measure BUSY width, optionally re-pulsing CNVST mid-conversion.
  task automatic wait_conv(input logic [1:0] md, input int repulse_at);
    int w;
    logic [1:0] exp_l;
    logic [DW-1:0] wd;
    w = 1;
    while (a_if.BUSY && w <= CONV + 50) begin
      @(negedge SYSCLK);
      if (w == repulse_at) a_if.ADC_CNVST = 1'b1;
      if (w == repulse_at + 2) a_if.ADC_CNVST = 1'b0;
      if (a_if.BUSY) w++;
    end
    a_if.ADC_CNVST = 1'b0;
    check_value("busy_width", w, CONV);
    for (int c = 0; c < 2; c++) begin
      wd = model_word(val_a[c], seed_a[c], md, par);
      exp_l[c] = (FBITS == DW + 1) ? 1'b0 : wd[DW-1];
    end
    check_value("lanes_at_busy_fall", a_if.ADC_SDOUT, exp_l);
  endtask

  // Controller readout at 12.5 MHz: sample on each SCLK rise.
  task automatic sclk_bits(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 2; c++) cap_a[c] = {cap_a[c][DW-1:0], a_if.ADC_SDOUT[c]};
      cap_b = {cap_b[DW-1:0], b_if.ADC_SDOUT[0]};
      a_if.ADC_SCLK = 1'b1;
      repeat (4) @(negedge SYSCLK);
      a_if.ADC_SCLK = 1'b0;
      repeat (4) @(negedge SYSCLK);
    end
  endtask

  task automatic run_frame(input logic [1:0] md, input int repulse_at, input int abort_bits);
    int d_a, d_b, a_a, a_b;
    logic [DW-1:0] wa [2];
    logic [DW-1:0] wb;
    d_a = done_a; d_b = done_b; a_a = abort_a; a_b = abort_b;
    start_conv(md);
    wait_conv(md, repulse_at);
    if (abort_bits > 0) begin
      sclk_bits(abort_bits);
      start_conv(md);
      wait_conv(md, 0);
      check_value("abort_pulse_a", abort_a, a_a + 1);
    end
    for (int c = 0; c < 2; c++) cap_a[c] = '0;
    cap_b = '0;
    sclk_bits(FBITS);
    repeat (2) @(negedge SYSCLK);
    for (int c = 0; c < 2; c++) wa[c] = model_word(val_a[c], seed_a[c], md, par);
    wb = model_word(val_b, 16'hFFFF, md, par);
    check_value("lane0_word", cap_a[0], {1'b0, wa[0]});
    check_value("lane1_word", cap_a[1], {1'b0, wa[1]});
    check_value("laneb_word", cap_b, {1'b0, wb});
    check_value("frame_done_a", done_a, d_a + 1);
    check_value("frame_done_b", done_b, d_b + 1);
    check_value("abort_count_a", abort_a, a_a + ((abort_bits > 0) ? 1 : 0));
    check_value("abort_count_b", abort_b, a_b + ((abort_bits > 0) ? 1 : 0));
    check_value("lanes_idle", a_if.ADC_SDOUT, 2'b11);
    frame_no++;
    $display("frame %0d mode=%0d repulse=%0d abort_bits=%0d lane0=%h lane1=%h laneb=%h",
             frame_no, md, repulse_at, abort_bits, cap_a[0], cap_a[1], cap_b);
    model_frame_done();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] md;
    int rp, ab;
    RESET_N        = 1'b0;
    a_if.ADC_CNVST = 1'b0;
    a_if.ADC_SCLK  = 1'b0;
    a_if.MODE      = 2'd0;
    model_reset();
    repeat (3) @(negedge SYSCLK);
    check_value("reset_lanes_a", a_if.ADC_SDOUT, 2'b11);
    check_value("reset_lanes_b", b_if.ADC_SDOUT, 1'b1);
    check_value("reset_busy", a_if.BUSY, 0);
    check_value("reset_done", a_if.FRAME_DONE, 0);
    check_value("reset_abort", a_if.FRAME_ABORT, 0);
    RESET_N = 1'b1;
    repeat (3) @(negedge SYSCLK);

    // Ramp frames and wrap on the single-lane instance.
    run_frame(2'd0, 0, 0);
    check_value("f1_lane0", cap_a[0], 16'hABCD);
    check_value("f1_lane1", cap_a[1], 16'hACCD);
    check_value("f1_laneb", cap_b, 16'hFFFF);
    run_frame(2'd0, 0, 0);
    check_value("f2_lane0", cap_a[0], 16'hABCE);
    check_value("f2_lane1", cap_a[1], 16'hACCE);
    check_value("f2_laneb", cap_b, 16'h0000);
    run_frame(2'd2, 0, 0);
    check_value("f3_laneb_inv", cap_b, 16'hFFFE);

    // Abort after 5 SCLKs, then a CNVST re-pulse during conversion.
    run_frame(2'd0, 0, 5);
    run_frame(2'd1, 60, 0);

    // Reset during bit 7 of a frame.
    a_if.MODE = 2'd0;
    start_conv(2'd0);
    wait_conv(2'd0, 0);
    sclk_bits(6);
    a_if.ADC_SCLK = 1'b1;
    repeat (2) @(negedge SYSCLK);
    RESET_N = 1'b0;
    #1;
    check_value("rst_mid_lanes_a", a_if.ADC_SDOUT, 2'b11);
    check_value("rst_mid_lanes_b", b_if.ADC_SDOUT, 1'b1);
    check_value("rst_mid_busy", a_if.BUSY, 0);
    @(negedge SYSCLK);
    a_if.ADC_SCLK = 1'b0;
    repeat (3) @(negedge SYSCLK);
    RESET_N = 1'b1;
    model_reset();
    repeat (3) @(negedge SYSCLK);
    run_frame(2'd0, 0, 0);
    check_value("post_rst_lane0", cap_a[0], 16'hABCD);
    check_value("post_rst_laneb", cap_b, 16'hFFFF);

    // Randomised frames: mode, re-pulse and abort point.
    for (int k = 0; k < 20; k++) begin
      md = 2'($urandom_range(0, 3));
      rp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 120)) : 0;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FBITS - 1)) : 0;
      run_frame(md, rp, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
